// File: rtl/led_lights.sv
// Shared definitions for the LED/seven-segment lights blocks: state encoding,
// decimal display ceiling and the terminal-count clamp.
package led_lights;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    HOLD     = 2'd2
  } cu_state_t;

  localparam logic [15:0] BCD_MAX = 16'd9999;
  localparam int          SCAN_W  = 18;

  // A zero or undisplayable limit falls back to the largest four-digit value.
  function automatic logic [15:0] eff_limit(input logic [15:0] lim);
    return ((lim == 16'd0) || (lim > BCD_MAX)) ? BCD_MAX : lim;
  endfunction

endpackage

// File: rtl/counting_up_if.sv
// Control and display bundle for the counting_up stopwatch.
interface counting_up_if;
  import led_lights::*;

  // start/halt are single-cycle pulses sampled on the rising clock edge with
  // no back-pressure; done is a registered one-cycle pulse, state is debug only.
  logic        start;
  logic        halt;
  logic [15:0] limit;
  logic [15:0] elapsed;
  logic        running;
  logic        done;
  logic [7:0]  seg;
  logic [3:0]  an;
  cu_state_t   state;

  modport master (output start, halt, limit,
                  input  elapsed, running, done, seg, an, state);
  modport slave  (input  start, halt, limit,
                  output elapsed, running, done, seg, an, state);
endinterface

// File: rtl/bin_to_bcd.sv
// Registered 16-bit binary to four-digit BCD (shift-add-3), one cycle latency.
module bin_to_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bin,
  output logic [15:0] bcd
);
  logic [15:0] bcd_d;
  logic [15:0] sh_b;

  always_comb begin
    bcd_d = '0;
    sh_b  = bin;
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd_d[4*d +: 4] >= 4'd5) bcd_d[4*d +: 4] = bcd_d[4*d +: 4] + 4'd3;
      end
      bcd_d = {bcd_d[14:0], sh_b[15]};
      sh_b  = {sh_b[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcd <= '0;
    else        bcd <= bcd_d;
  end
endmodule

// File: rtl/clock_divider.sv
// Enable-gated prescaler: tick fires on the DIV-th enabled cycle, then every DIV.
module clock_divider #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Dropping en parks the count at zero so re-enabling starts a fresh period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (!en || cnt == LAST) cnt <= '0;
    else                         cnt <= cnt + W'(1);
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/seg7_display.sv
// Four-digit multiplexed common-anode driver; active-low seg and an, dp off.
module seg7_display #(
  parameter int SCAN_W = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blank,
  input  logic [15:0] bcd,
  output logic [7:0]  seg,
  output logic [3:0]  an
);
  logic [SCAN_W-1:0] scan;
  logic [1:0]        sel;
  logic [3:0]        digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan <= '0;
    else        scan <= scan + SCAN_W'(1);
  end

  assign sel = scan[SCAN_W-1 -: 2];

  always_comb begin
    digit = bcd[{sel, 2'b00} +: 4];
    an    = 4'hF;
    seg   = 8'hFF;
    if (!blank) begin
      an = ~(4'b0001 << sel);
      case (digit)
        4'd0:    seg = 8'hC0;
        4'd1:    seg = 8'hF9;
        4'd2:    seg = 8'hA4;
        4'd3:    seg = 8'hB0;
        4'd4:    seg = 8'h99;
        4'd5:    seg = 8'h92;
        4'd6:    seg = 8'h82;
        4'd7:    seg = 8'hF8;
        4'd8:    seg = 8'h80;
        4'd9:    seg = 8'h90;
        default: seg = 8'hFF;
      endcase
    end
  end
endmodule

// File: rtl/counting_up.sv
// Up-counting stopwatch: counts ticks from start up to a clamped terminal count,
// freezes on halt or terminal count, and shows the count on a 4-digit display.
module counting_up
  import led_lights::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic          clk,
  input  logic          rst,
  counting_up_if.slave  bus
);
  logic        rst_n;
  cu_state_t   state_q, state_d;
  logic [15:0] elapsed_q, elapsed_d;
  logic [15:0] lim_q, lim_d;
  logic        done_q, done_d;
  logic        tick;
  logic [16:0] elapsed_inc;
  logic [15:0] bcd;
  logic [7:0]  seg;
  logic [3:0]  an;

  // The reused blocks take an active-low reset.
  assign rst_n = ~rst;

  clock_divider #(.DIV(TICK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == COUNTING),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
      lim_q     <= BCD_MAX;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      lim_q     <= lim_d;
      done_q    <= done_d;
    end
  end

  // One extra bit keeps the terminal comparison free of wrap-around.
  assign elapsed_inc = {1'b0, elapsed_q} + 17'd1;

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    lim_d     = lim_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (bus.start) begin
          state_d   = COUNTING;
          elapsed_d = '0;
          lim_d     = eff_limit(bus.limit);
        end
      end
      COUNTING: begin
        if (bus.halt) begin
          state_d = HOLD;
        end else if (tick) begin
          if (elapsed_inc >= {1'b0, lim_q}) begin
            elapsed_d = lim_q;
            state_d   = HOLD;
            done_d    = 1'b1;
          end else begin
            elapsed_d = elapsed_inc[15:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bin_to_bcd u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (elapsed_q),
    .bcd   (bcd)
  );

  seg7_display #(.SCAN_W(SCAN_W)) u_disp (
    .clk   (clk),
    .rst_n (rst_n),
    .blank (state_q == IDLE),
    .bcd   (bcd),
    .seg   (seg),
    .an    (an)
  );

  assign bus.elapsed = elapsed_q;
  assign bus.running = (state_q == COUNTING);
  assign bus.done    = done_q;
  assign bus.seg     = seg;
  assign bus.an      = an;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_counting_up.sv
// Directed bench for counting_up with TICK_DIV=4; expected counts are queued
// when a start is driven and popped as the count advances.
module tb_counting_up;
  import led_lights::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic [15:0] exp_q[$];

  counting_up_if bus();

  counting_up #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_next(input string tag);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) check(tag, bus.elapsed, exp_q.pop_front());
  endtask

  function automatic logic [7:0] seg_code(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic pulse_start(input logic [15:0] lim, input logic with_halt);
    bus.limit = lim;
    bus.start = 1'b1;
    bus.halt  = with_halt;
    cycles(1);
    bus.start = 1'b0;
    bus.halt  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_elapsed"}, bus.elapsed, 0);
    check({tag, "_running"}, bus.running, 0);
    check({tag, "_done"},    bus.done, 0);
    check({tag, "_an"},      bus.an, 4'hF);
    check({tag, "_seg"},     bus.seg, 8'hFF);
    check({tag, "_state"},   bus.state, IDLE);
    check({tag, "_lim_q"},   dut.lim_q, 9999);
  endtask

  initial begin
    int waited;
    logic seen;
    logic [15:0] max_el;

    bus.start = 1'b0;
    bus.halt  = 1'b0;
    bus.limit = '0;
    cycles(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    cycles(1);

    // Basic count to 3.
    pulse_start(16'd3, 1'b0);
    for (int v = 1; v <= 3; v++) exp_q.push_back(16'(v));
    check("basic_running", bus.running, 1);
    check("basic_lim_q", dut.lim_q, 3);
    for (int k = 0; k < 3; k++) begin
      cycles(3);
      check("basic_hold_between", bus.elapsed, k);
      cycles(1);
      check_next("basic_inc");
    end
    check("basic_done_pulse", bus.done, 1);
    check("basic_state_hold", bus.state, HOLD);
    check("basic_running_off", bus.running, 0);
    cycles(1);
    check("basic_done_single", bus.done, 0);
    check("basic_an", bus.an, 4'b1110);
    check("basic_seg", bus.seg, seg_code(3));
    cycles(8);
    check("basic_elapsed_held", bus.elapsed, 3);
    check("basic_done_count", done_cnt, 1);

    // Halt six cycles after start, then restart.
    pulse_start(16'd100, 1'b0);
    exp_q.push_back(16'd1);
    cycles(5);
    check_next("halt_first_inc");
    bus.halt = 1'b1;
    cycles(1);
    bus.halt = 1'b0;
    check("halt_state", bus.state, HOLD);
    check("halt_running", bus.running, 0);
    cycles(10);
    check("halt_frozen", bus.elapsed, 1);
    check("halt_no_done", done_cnt, 1);
    pulse_start(16'd100, 1'b0);
    exp_q.push_back(16'd1);
    check("restart_cleared", bus.elapsed, 0);
    check("restart_running", bus.running, 1);
    cycles(3);
    check("restart_not_yet", bus.elapsed, 0);
    cycles(1);
    check_next("restart_inc");

    // Halt coinciding with the second tick.
    cycles(3);
    bus.halt = 1'b1;
    cycles(1);
    bus.halt = 1'b0;
    check("collide_elapsed", bus.elapsed, 1);
    check("collide_state", bus.state, HOLD);
    check("collide_no_done", done_cnt, 1);

    // Halt in HOLD ignored; start during COUNTING ignored.
    bus.halt = 1'b1;
    cycles(1);
    bus.halt = 1'b0;
    check("hold_halt_ignored", bus.state, HOLD);
    pulse_start(16'd50, 1'b0);
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    cycles(5);
    check_next("ign_first_inc");
    pulse_start(16'd50, 1'b0);
    check("ign_start_state", bus.state, COUNTING);
    check("ign_start_elapsed", bus.elapsed, 1);
    cycles(2);
    check_next("ign_continues");
    cycles(12);
    check("pre_reset_elapsed", bus.elapsed, 5);

    // Asynchronous reset mid-count; start while held in reset is dropped.
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    pulse_start(16'd10, 1'b0);
    cycles(1);
    check("rst_start_ignored", bus.state, IDLE);
    rst = 1'b0;
    cycles(2);
    check("post_rst_idle", bus.state, IDLE);

    // Start and halt together in IDLE act as start.
    pulse_start(16'd2, 1'b1);
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    check("sh_state", bus.state, COUNTING);
    check("sh_elapsed", bus.elapsed, 0);
    cycles(4);
    check_next("sh_inc1");
    cycles(4);
    check_next("sh_inc2");
    check("sh_done", bus.done, 1);
    check("sh_hold", bus.state, HOLD);
    cycles(1);
    check("sh_done_count", done_cnt, 2);

    // Limit clamp: 12000 and 0 both become 9999; run 0 to the terminal count.
    pulse_start(16'd12000, 1'b0);
    check("clamp_big_lim_q", dut.lim_q, 9999);
    bus.halt = 1'b1;
    cycles(1);
    bus.halt = 1'b0;
    pulse_start(16'd0, 1'b0);
    check("clamp_zero_lim_q", dut.lim_q, 9999);
    check("clamp_zero_elapsed", bus.elapsed, 0);
    exp_q.push_back(16'd9999);
    waited = 0;
    seen = 1'b0;
    max_el = '0;
    while (!seen && waited < 9999 * 4 + 100) begin
      cycles(1);
      waited++;
      if (bus.elapsed > max_el) max_el = bus.elapsed;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("clamp_done_seen", seen, 1);
    check("clamp_cycles", waited, 9999 * 4);
    check_next("clamp_final");
    check("clamp_state", bus.state, HOLD);
    check("clamp_max", max_el, 9999);
    cycles(1);
    check("clamp_done_count", done_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counting_up.md
COUNTING_UP -- requirements
Module: counting_up

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter: TICK_DIV, default 25_000_000, clock cycles per count increment.
REQ-003 clk  input  1  system clock; all state is updated on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 start  input  1  single-cycle pulse; clears the count and begins counting.
REQ-006 halt  input  1  single-cycle pulse; freezes the count.
REQ-007 limit  input  16  terminal count, sampled on an accepted start.
REQ-008 elapsed  output  16  current count, binary.
REQ-009 running  output  1  high while counting.
REQ-010 done  output  1  one-cycle pulse when the terminal count is reached.
REQ-011 seg  output  8  seven-segment cathodes, driven as by the existing display path.
REQ-012 an  output  4  seven-segment anodes.

Function
REQ-013 The FSM SHALL have three states: IDLE, COUNTING, HOLD.
REQ-014 IDLE->COUNTING on start; on that edge elapsed<=0 and lim_q<=eff(limit).
REQ-015 eff(limit) SHALL be 9999 when limit is 0 or greater than 9999; otherwise it SHALL be limit.
REQ-016 The prescaler SHALL count only in COUNTING and SHALL restart at 0 on every entry to COUNTING.
REQ-017 The prescaler SHALL emit tick on the TICK_DIV-th cycle after entry, and every TICK_DIV cycles after that.
REQ-018 In COUNTING, on tick with elapsed+1 < lim_q: elapsed SHALL increment.
REQ-019 In COUNTING, on tick with elapsed+1 == lim_q: elapsed<=lim_q, state<=HOLD and done<=1, all on the same edge.
REQ-020 In COUNTING, halt SHALL move the state to HOLD with elapsed unchanged and no done pulse.
REQ-021 halt coinciding with tick SHALL win: no increment and no done.
REQ-022 start while in COUNTING SHALL be ignored.
REQ-023 HOLD->COUNTING on start, with elapsed cleared to 0 and lim_q resampled (restart).
REQ-024 halt in HOLD or IDLE SHALL be ignored; start and halt together in IDLE or HOLD SHALL be treated as start only.
REQ-025 running SHALL be 1 exactly while the state is COUNTING.
REQ-026 done SHALL be registered and high for exactly one cycle per terminal event.
REQ-027 The display SHALL be valid (digits shown) in COUNTING and HOLD and blanked in IDLE.
REQ-028 The display SHALL show elapsed in decimal through the existing BCD conversion; its latency is that of the conversion, and elapsed itself SHALL have zero added latency.
REQ-029 elapsed SHALL never exceed 9999.
REQ-030 The 16-bit arithmetic SHALL never wrap.

Reset
REQ-031 Reset SHALL force: state=IDLE, elapsed=0, lim_q=9999, prescaler=0, running=0, done=0, display blanked.
REQ-032 Reset asserted mid-count SHALL abort immediately; start is honoured only after reset deasserts.

Structure
REQ-033 The state enum and the constant BCD_MAX=9999 SHALL live in the shared led_lights package.
REQ-034 The block SHALL reuse the existing clock_divider, bin_to_bcd and seg7_display blocks, adapting reset polarity locally (rst inverted to their active-low reset).
REQ-035 No new sub-module SHALL be created; the FSM and counter SHALL stay in counting_up.

Verification (TICK_DIV=4)
REQ-036 Basic count: rst, then start with limit=3. Required: elapsed=1, 2, 3 at 4, 8 and 12 cycles after start; done high one cycle with the final increment; running=0 afterwards; elapsed holds 3.
REQ-037 Halt mid-count: halt 6 cycles after start (limit=100). Required: elapsed=1 and frozen; running=0; no done. A later start clears the count and the next increment comes 4 cycles after it.
REQ-038 Collision: halt on the same cycle as the 2nd tick. Required: elapsed stays 1 and the state becomes HOLD.
REQ-039 Limit clamp: limit=0 and limit=12000. Required: lim_q=9999; a forced elapsed of 9998 plus one tick gives 9999, done and HOLD.
REQ-040 Reset mid-count: assert rst while elapsed=5. Required: all outputs at reset values asynchronously and an blanked; start without rst deasserted is ignored.
REQ-041 Ignored inputs: start during COUNTING does not restart (elapsed continues); start and halt together in IDLE enter COUNTING.
